// File: rtl/peri_dma_arb.sv
`default_nettype none
// ============================================================================
// Module   : peri_dma_arb
// Purpose  : Shares one DMA memory port between NUM_REQ DMA engines, one
//            transaction at a time. Define PERI_DMA_ARB_FIXED_PRIO_EN for
//            fixed priority (lowest index wins) instead of round-robin.
// Revision : 1.0 - initial release
// ============================================================================
module peri_dma_arb #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                            clk,
  input  logic                            rstn,
  input  logic [NUM_REQ-1:0]              req_valid,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic [NUM_REQ-1:0]              req_write,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr,
  input  logic [NUM_REQ*LEN_WIDTH-1:0]    req_len,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_wdata,
  input  logic [NUM_REQ-1:0]              req_wvalid,
  output logic [NUM_REQ-1:0]              req_wready,
  output logic [DATA_WIDTH-1:0]           req_rdata,
  output logic [NUM_REQ-1:0]              req_rvalid,
  output logic [NUM_REQ-1:0]              req_rlast,
  output logic [NUM_REQ-1:0]              req_bvalid,
  output logic                            m_cmd_valid,
  input  logic                            m_cmd_ready,
  output logic                            m_cmd_write,
  output logic [ADDR_WIDTH-1:0]           m_cmd_addr,
  output logic [LEN_WIDTH-1:0]            m_cmd_len,
  output logic [DATA_WIDTH-1:0]           m_wdata,
  output logic                            m_wvalid,
  output logic                            m_wlast,
  input  logic                            m_wready,
  input  logic [DATA_WIDTH-1:0]           m_rdata,
  input  logic                            m_rvalid,
  input  logic                            m_rlast,
  input  logic                            m_bvalid,
  output logic [$clog2(NUM_REQ)-1:0]      gnt_id,
  output logic                            busy
);

  localparam int c_ID_W = $clog2(NUM_REQ);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CMD   = 3'd1,
    S_WDATA = 3'd2,
    S_WRESP = 3'd3,
    S_RDATA = 3'd4
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [c_ID_W-1:0]     r_gnt_id;
  logic [c_ID_W-1:0]     w_pick;
  logic [LEN_WIDTH-1:0]  r_len;
  logic [LEN_WIDTH:0]    r_beat_cnt;
  logic [NUM_REQ-1:0]    w_gnt_oh;
  logic                  w_any_req;
  logic                  w_cmd_hs;
  logic                  w_wbeat;
  logic                  w_wlast_beat;
  logic                  w_done;
  logic [LEN_WIDTH-1:0]  w_sel_len;

  assign w_any_req    = |req_valid;
  assign w_gnt_oh     = {{(NUM_REQ-1){1'b0}}, 1'b1} << r_gnt_id;
  assign w_sel_len    = req_len[r_gnt_id*LEN_WIDTH +: LEN_WIDTH];
  assign w_cmd_hs     = (r_state == S_CMD) && m_cmd_ready;
  assign w_wbeat      = (r_state == S_WDATA) && req_wvalid[r_gnt_id] && m_wready;
  // beat_cnt is one bit wider than len so len=all-ones never wraps
  assign w_wlast_beat = (r_beat_cnt == {1'b0, r_len});
  assign w_done       = ((r_state == S_WRESP) && m_bvalid) ||
                        ((r_state == S_RDATA) && m_rvalid && m_rlast);
  assign gnt_id       = r_gnt_id;
  assign busy         = (r_state != S_IDLE);

`ifdef PERI_DMA_ARB_FIXED_PRIO_EN
  always_comb begin
    w_pick = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_valid[k]) w_pick = c_ID_W'(k);
    end
  end
`else
  logic [c_ID_W-1:0] r_rr_ptr;
  logic [c_ID_W-1:0] w_rr_nxt;
  logic [c_ID_W-1:0] w_cand;
  logic              w_found;
  int                w_idx;

  assign w_rr_nxt = (r_gnt_id == c_ID_W'(NUM_REQ - 1)) ? '0 : r_gnt_id + 1'b1;

  // first requester at or after rr_ptr, wrapping around
  always_comb begin
    w_pick  = r_rr_ptr;
    w_found = 1'b0;
    w_idx   = 0;
    w_cand  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = int'(r_rr_ptr) + k;
      if (w_idx >= NUM_REQ) w_idx = w_idx - NUM_REQ;
      w_cand = c_ID_W'(w_idx);
      if (!w_found && req_valid[w_cand]) begin
        w_pick  = w_cand;
        w_found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn)       r_rr_ptr <= '0;
    else if (w_done) r_rr_ptr <= w_rr_nxt;
  end
`endif

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state    <= S_IDLE;
      r_gnt_id   <= '0;
      r_len      <= '0;
      r_beat_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if ((r_state == S_IDLE) && w_any_req) r_gnt_id <= w_pick;
      if (w_cmd_hs) begin
        r_len      <= w_sel_len;
        r_beat_cnt <= '0;
      end else if (w_wbeat) begin
        r_beat_cnt <= r_beat_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    req_ready   = '0;
    req_wready  = '0;
    req_rdata   = '0;
    req_rvalid  = '0;
    req_rlast   = '0;
    req_bvalid  = '0;
    m_cmd_valid = 1'b0;
    m_cmd_write = 1'b0;
    m_cmd_addr  = '0;
    m_cmd_len   = '0;
    m_wdata     = '0;
    m_wvalid    = 1'b0;
    m_wlast     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_any_req) w_state_nxt = S_CMD;
      end
      S_CMD: begin
        m_cmd_valid = 1'b1;
        m_cmd_write = req_write[r_gnt_id];
        m_cmd_addr  = req_addr[r_gnt_id*ADDR_WIDTH +: ADDR_WIDTH];
        m_cmd_len   = w_sel_len;
        if (m_cmd_ready) begin
          req_ready   = w_gnt_oh;
          w_state_nxt = req_write[r_gnt_id] ? S_WDATA : S_RDATA;
        end
      end
      S_WDATA: begin
        m_wvalid   = req_wvalid[r_gnt_id];
        m_wdata    = req_wdata[r_gnt_id*DATA_WIDTH +: DATA_WIDTH];
        m_wlast    = w_wlast_beat;
        req_wready = m_wready ? w_gnt_oh : '0;
        if (w_wbeat && w_wlast_beat) w_state_nxt = S_WRESP;
      end
      S_WRESP: begin
        if (m_bvalid) begin
          req_bvalid  = w_gnt_oh;
          w_state_nxt = S_IDLE;
        end
      end
      S_RDATA: begin
        req_rdata  = m_rdata;
        req_rvalid = m_rvalid ? w_gnt_oh : '0;
        req_rlast  = m_rlast ? w_gnt_oh : '0;
        if (m_rvalid && m_rlast) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_peri_dma_arb.sv
`default_nettype none
// Directed self-checking bench for peri_dma_arb (NUM_REQ=2, 32-bit addr/data, 8-bit len).
module tb_peri_dma_arb;

  logic        clk = 1'b0;
  logic        rstn;
  logic [1:0]  req_valid, req_ready, req_write, req_wvalid, req_wready;
  logic [1:0]  req_rvalid, req_rlast, req_bvalid;
  logic [63:0] req_addr, req_wdata;
  logic [15:0] req_len;
  logic [31:0] req_rdata;
  logic        m_cmd_valid, m_cmd_ready, m_cmd_write;
  logic [31:0] m_cmd_addr, m_wdata, m_rdata;
  logic [7:0]  m_cmd_len;
  logic        m_wvalid, m_wlast, m_wready, m_rvalid, m_rlast, m_bvalid;
  logic [0:0]  gnt_id;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;

  peri_dma_arb #(.NUM_REQ(2), .ADDR_WIDTH(32), .DATA_WIDTH(32), .LEN_WIDTH(8)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_len(req_len), .req_wdata(req_wdata),
    .req_wvalid(req_wvalid), .req_wready(req_wready), .req_rdata(req_rdata),
    .req_rvalid(req_rvalid), .req_rlast(req_rlast), .req_bvalid(req_bvalid),
    .m_cmd_valid(m_cmd_valid), .m_cmd_ready(m_cmd_ready), .m_cmd_write(m_cmd_write),
    .m_cmd_addr(m_cmd_addr), .m_cmd_len(m_cmd_len),
    .m_wdata(m_wdata), .m_wvalid(m_wvalid), .m_wlast(m_wlast), .m_wready(m_wready),
    .m_rdata(m_rdata), .m_rvalid(m_rvalid), .m_rlast(m_rlast), .m_bvalid(m_bvalid),
    .gnt_id(gnt_id), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // issue one command from an idle arbiter and complete the handshake
  task automatic do_cmd(input int id, input logic wr, input logic [31:0] addr, input logic [7:0] len);
    req_valid[id]            = 1'b1;
    req_write[id]            = wr;
    req_addr[id*32 +: 32]    = addr;
    req_len[id*8 +: 8]       = len;
    #1 check("cmd not yet valid", {63'd0, m_cmd_valid}, 64'd0);
    cycle();
    check("cmd valid", {63'd0, m_cmd_valid}, 64'd1);
    check("cmd gnt_id", {63'd0, gnt_id}, 64'(id));
    check("cmd addr", {32'd0, m_cmd_addr}, {32'd0, addr});
    check("cmd len", {56'd0, m_cmd_len}, {56'd0, len});
    check("cmd write", {63'd0, m_cmd_write}, {63'd0, wr});
    m_cmd_ready = 1'b1;
    #1 check("cmd req_ready", {62'd0, req_ready}, 64'd1 << id);
    cycle();
    req_valid[id] = 1'b0;
    m_cmd_ready   = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    int beat;
    int nfwd;
    logic [0:0] exp_g [4];
`ifdef PERI_DMA_ARB_FIXED_PRIO_EN
    exp_g = '{1'b0, 1'b0, 1'b0, 1'b0};
`else
    exp_g = '{1'b0, 1'b1, 1'b0, 1'b1};
`endif
    rstn = 1'b0; req_valid = '0; req_write = '0; req_wvalid = '0;
    req_addr = '0; req_wdata = '0; req_len = '0;
    m_cmd_ready = 1'b0; m_wready = 1'b0; m_rdata = '0; m_rvalid = 1'b0;
    m_rlast = 1'b0; m_bvalid = 1'b0;
    cycle(); cycle();
    check("rst busy", {63'd0, busy}, 64'd0);
    check("rst gnt_id", {63'd0, gnt_id}, 64'd0);
    check("rst cmd_valid", {63'd0, m_cmd_valid}, 64'd0);
    check("rst wvalid", {63'd0, m_wvalid}, 64'd0);
    rstn = 1'b1;
    cycle();

    // single read, len=3
    do_cmd(0, 1'b0, 32'h8000_0000, 8'd3);
    for (int b = 0; b < 4; b++) begin
      m_rvalid = 1'b1; m_rdata = 32'hA000_0000 + b; m_rlast = (b == 3);
      #1;
      check("t1 rvalid", {62'd0, req_rvalid}, 64'd1);
      check("t1 rdata", {32'd0, req_rdata}, {32'd0, 32'hA000_0000 + b});
      check("t1 rlast", {62'd0, req_rlast}, (b == 3) ? 64'd1 : 64'd0);
      cycle();
    end
    m_rvalid = 1'b0; m_rlast = 1'b0;
    #1 check("t1 idle", {63'd0, busy}, 64'd0);
    cycle();

    // write len=0 from req1
    do_cmd(1, 1'b1, 32'h0000_4000, 8'd0);
    req_wvalid[1] = 1'b1; req_wdata[63:32] = 32'h1234_5678; m_wready = 1'b1;
    #1;
    check("t2 wvalid", {63'd0, m_wvalid}, 64'd1);
    check("t2 wlast", {63'd0, m_wlast}, 64'd1);
    check("t2 wdata", {32'd0, m_wdata}, 64'h1234_5678);
    check("t2 wready", {62'd0, req_wready}, 64'd2);
    cycle();
    req_wvalid[1] = 1'b0; m_wready = 1'b0;
    #1 check("t2 wresp busy", {63'd0, busy}, 64'd1);
    m_bvalid = 1'b1;
    #1 check("t2 bvalid", {62'd0, req_bvalid}, 64'd2);
    check("t2 gnt_id", {63'd0, gnt_id}, 64'd1);
    cycle();
    m_bvalid = 1'b0;
    #1 check("t2 idle", {63'd0, busy}, 64'd0);

    // both requesters held, reads len=1
    req_valid = 2'b11; req_write = 2'b00; req_len = {8'd1, 8'd1};
    cycle();
    for (int t = 0; t < 4; t++) begin
      check("t3 cmd valid", {63'd0, m_cmd_valid}, 64'd1);
      check("t3 gnt", {63'd0, gnt_id}, {63'd0, exp_g[t]});
      m_cmd_ready = 1'b1;
      #1 check("t3 req_ready", {62'd0, req_ready}, 64'd1 << exp_g[t]);
      cycle();
      m_cmd_ready = 1'b0;
      for (int b = 0; b < 2; b++) begin
        m_rvalid = 1'b1; m_rlast = (b == 1);
        cycle();
      end
      m_rvalid = 1'b0; m_rlast = 1'b0;
      #1 check("t3 idle gap", {63'd0, busy}, 64'd0);
      if (t == 3) req_valid = 2'b00;
      cycle();
    end

    // write len=7 with m_wready toggling
    do_cmd(0, 1'b1, 32'h0000_1000, 8'd7);
    beat = 0;
    for (int c = 0; c < 40 && beat < 8; c++) begin
      req_wvalid[0] = 1'b1; req_wdata[31:0] = 32'hD000_0000 + beat; m_wready = (c % 2 == 0);
      #1;
      check("t4 wdata", {32'd0, m_wdata}, {32'd0, 32'hD000_0000 + beat});
      check("t4 wlast", {63'd0, m_wlast}, (beat == 7) ? 64'd1 : 64'd0);
      check("t4 wready", {62'd0, req_wready}, m_wready ? 64'd1 : 64'd0);
      if (m_wready) beat++;
      cycle();
    end
    req_wvalid = '0; m_wready = 1'b0;
    #1;
    check("t4 beats", 64'(beat), 64'd8);
    check("t4 wresp busy", {63'd0, busy}, 64'd1);
    check("t4 wvalid off", {63'd0, m_wvalid}, 64'd0);
    m_bvalid = 1'b1;
    #1 check("t4 bvalid", {62'd0, req_bvalid}, 64'd1);
    cycle();
    m_bvalid = 1'b0;

    // reset during RDATA beat 2
    do_cmd(1, 1'b0, 32'h0000_3000, 8'd3);
    m_rvalid = 1'b1; m_rdata = 32'h5555_0001;
    #1 check("t5 beat1", {62'd0, req_rvalid}, 64'd2);
    cycle();
    m_rdata = 32'h5555_0002; rstn = 1'b0;
    #1 check("t5 beat2", {62'd0, req_rvalid}, 64'd2);
    cycle();
    check("t5 busy", {63'd0, busy}, 64'd0);
    check("t5 rvalid", {62'd0, req_rvalid}, 64'd0);
    check("t5 rdata", {32'd0, req_rdata}, 64'd0);
    check("t5 gnt_id", {63'd0, gnt_id}, 64'd0);
    m_rvalid = 1'b0; rstn = 1'b1;
    cycle();
    do_cmd(1, 1'b0, 32'h0000_3100, 8'd0);
    m_rvalid = 1'b1; m_rlast = 1'b1;
    cycle();
    m_rvalid = 1'b0; m_rlast = 1'b0;
    #1 check("t5 done", {63'd0, busy}, 64'd0);

    // len=0xFF read
    do_cmd(0, 1'b0, 32'h0001_0000, 8'hFF);
    nfwd = 0;
    for (int b = 0; b < 256; b++) begin
      m_rvalid = 1'b1; m_rlast = (b == 255);
      #1;
      if (req_rvalid == 2'b01) nfwd++;
      if (b == 255) check("t6 busy before last", {63'd0, busy}, 64'd1);
      cycle();
    end
    m_rvalid = 1'b0; m_rlast = 1'b0;
    #1;
    check("t6 beats fwd", 64'(nfwd), 64'd256);
    check("t6 idle", {63'd0, busy}, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
